// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: per-channel OFF / ON / BLINK / BREATHE patterns,
// driven by a per-channel tick counter and a shared PWM counter, with a
// configuration port that accepts at most one request every second cycle.
module led_pattern_ctrl #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 11,
    parameter int PWM_W      = 4,
    parameter int ACTIVE_LOW = 1,
    localparam int CH_W      = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] led_o
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    localparam logic [PWM_W-1:0] LVL_MAX  = {PWM_W{1'b1}};
    localparam logic             POL_BIT  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // Odd channels start in phase 1 so default pairs blink in anti-phase.
    function automatic logic [NUM_CH-1:0] odd_mask();
        logic [NUM_CH-1:0] m;
        for (int i = 0; i < NUM_CH; i++) begin
            m[i] = (i % 2 == 1) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    localparam logic [NUM_CH-1:0] PHASE_RST = odd_mask();
    localparam logic [NUM_CH-1:0] LED_RST   = PHASE_RST ^ {NUM_CH{POL_BIT}};

    logic [NUM_CH-1:0][1:0]       mode_q,  mode_d;
    logic [NUM_CH-1:0][CNT_W-1:0] half_q,  half_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q,   cnt_d;
    logic [NUM_CH-1:0]            phase_q, phase_d;
    logic [NUM_CH-1:0][PWM_W-1:0] lvl_q,   lvl_d;
    logic [NUM_CH-1:0]            dir_q,   dir_d;
    logic [PWM_W-1:0]             pwm_cnt_q, pwm_cnt_d;
    logic                         cfg_ready_q, cfg_ready_d;
    logic [NUM_CH-1:0]            led_o_q, led_o_d;

    logic                         accept_s;
    logic [NUM_CH-1:0]            step_s;
    logic [NUM_CH-1:0]            lit_s;

    // Next-state logic: accept overrides step; patterns advance on step events.
    always_comb begin
        accept_s    = cfg_valid && cfg_ready_q;
        cfg_ready_d = !accept_s;
        pwm_cnt_d   = pwm_cnt_q + PWM_W'(1);
        mode_d      = mode_q;
        half_d      = half_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        lvl_d       = lvl_q;
        dir_d       = dir_q;
        step_s      = '0;
        lit_s       = '0;
        led_o_d     = led_o_q;
        for (int i = 0; i < NUM_CH; i++) begin
            step_s[i] = (cnt_q[i] == half_q[i]);

            if (accept_s && (cfg_ch == CH_W'(i))) begin
                mode_d[i]  = cfg_mode;
                half_d[i]  = cfg_half;
                cnt_d[i]   = '0;
                phase_d[i] = 1'b0;
                lvl_d[i]   = '0;
                dir_d[i]   = 1'b1;
            end else begin
                if (step_s[i]) begin
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end

                if (step_s[i] && (mode_q[i] == MODE_BLINK)) begin
                    phase_d[i] = !phase_q[i];
                end else begin
                    phase_d[i] = phase_q[i];
                end

                if (step_s[i] && (mode_q[i] == MODE_BREATHE)) begin
                    if (dir_q[i]) begin
                        if (lvl_q[i] != LVL_MAX) begin
                            lvl_d[i] = lvl_q[i] + PWM_W'(1);
                        end else begin
                            lvl_d[i] = lvl_q[i];
                        end
                        dir_d[i] = (lvl_d[i] == LVL_MAX) ? 1'b0 : 1'b1;
                    end else begin
                        if (lvl_q[i] != '0) begin
                            lvl_d[i] = lvl_q[i] - PWM_W'(1);
                        end else begin
                            lvl_d[i] = lvl_q[i];
                        end
                        dir_d[i] = (lvl_d[i] == '0) ? 1'b1 : 1'b0;
                    end
                end else begin
                    lvl_d[i] = lvl_q[i];
                    dir_d[i] = dir_q[i];
                end
            end

            case (mode_q[i])
                MODE_OFF:     lit_s[i] = 1'b0;
                MODE_ON:      lit_s[i] = 1'b1;
                MODE_BLINK:   lit_s[i] = phase_q[i];
                MODE_BREATHE: lit_s[i] = (pwm_cnt_q < lvl_q[i]);
                default:      lit_s[i] = 1'b0;
            endcase
            led_o_d[i] = lit_s[i] ^ POL_BIT;
        end
    end

    // State and output registers with asynchronous reset to the default pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= MODE_BLINK;
                half_q[i] <= {CNT_W{1'b1}};
                cnt_q[i]  <= '0;
                lvl_q[i]  <= '0;
            end
            phase_q     <= PHASE_RST;
            dir_q       <= {NUM_CH{1'b1}};
            pwm_cnt_q   <= '0;
            cfg_ready_q <= 1'b1;
            led_o_q     <= LED_RST;
        end else begin
            mode_q      <= mode_d;
            half_q      <= half_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            lvl_q       <= lvl_d;
            dir_q       <= dir_d;
            pwm_cnt_q   <= pwm_cnt_d;
            cfg_ready_q <= cfg_ready_d;
            led_o_q     <= led_o_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign led_o     = led_o_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl. Three channels are used so that a
// 2-bit cfg_ch can address a non-existent channel (index 3); PWM_W = 2 keeps
// the breathe triangle short (0,1,2,3,2,1,0,...).
module tb_led_pattern_ctrl;

    localparam int NUM_CH     = 3;
    localparam int CNT_W      = 11;
    localparam int PWM_W      = 2;
    localparam int ACTIVE_LOW = 1;
    localparam int CH_W       = 2;
    localparam int LMAX       = (1 << PWM_W) - 1;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch    = '0;
    logic [1:0]        cfg_mode  = 2'd0;
    logic [CNT_W-1:0]  cfg_half  = '0;
    logic [NUM_CH-1:0] led_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    led_pattern_ctrl #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .PWM_W     (PWM_W),
        .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_half (cfg_half),
        .led_o    (led_o)
    );

    // ---------------- reference model ----------------
    // Each channel is described by its mode, half and the number of cycles
    // elapsed since it was configured; phase/level are derived in closed form.
    int m_mode[NUM_CH];
    int m_half[NUM_CH];
    int m_n[NUM_CH];
    int m_ph0[NUM_CH];
    int m_pwm;
    bit m_ready;

    typedef struct packed {
        logic [NUM_CH-1:0] led;
        logic              rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_push;
    exp_t e_pop;
    bit   m_acc;

    function automatic int tri_lvl(input int k);
        int p;
        p = k % (2 * LMAX);
        return (p <= LMAX) ? p : (2 * LMAX - p);
    endfunction

    function automatic bit model_lit(input int ch);
        int k;
        k = m_n[ch] / (m_half[ch] + 1);
        case (m_mode[ch])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((m_ph0[ch] + k) % 2) == 1;
            default: return (m_pwm % (LMAX + 1)) < tri_lvl(k);
        endcase
    endfunction

    function automatic void model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_mode[ch] = 2;
            m_half[ch] = (1 << CNT_W) - 1;
            m_n[ch]    = 0;
            m_ph0[ch]  = ch % 2;
        end
        m_pwm   = 0;
        m_ready = 1'b1;
    endfunction

    // Model: predict what each clock edge will register, then advance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
            exp_q.delete();
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                e_push.led[ch] = model_lit(ch) ^ (ACTIVE_LOW != 0);
            end
            m_acc      = cfg_valid && m_ready;
            e_push.rdy = !m_acc;
            exp_q.push_back(e_push);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (m_acc && (int'(cfg_ch) == ch)) begin
                    m_mode[ch] = int'(cfg_mode);
                    m_half[ch] = int'(cfg_half);
                    m_n[ch]    = 0;
                    m_ph0[ch]  = 0;
                end else begin
                    m_n[ch] = m_n[ch] + 1;
                end
            end
            m_pwm   = m_pwm + 1;
            m_ready = !m_acc;
        end
    end

    // Monitor: the DUT presents led_o/cfg_ready every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (rst_n && (exp_q.size() > 0)) begin
            e_pop = exp_q.pop_front();
            vectors++;
            if ((led_o !== e_pop.led) || (cfg_ready !== e_pop.rdy)) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t: led_o=%b cfg_ready=%b, expected led_o=%b cfg_ready=%b",
                         $time, led_o, cfg_ready, e_pop.led, e_pop.rdy);
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Called at posedge+1 with cfg_ready known to be 1; returns at accept+1.
    task automatic send(input int ch, input int mode, input int half);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_mode  = 2'(mode);
        cfg_half  = CNT_W'(half);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset state before any clock edge is relied on.
        #22;
        check("reset_led", int'(led_o), 5);
        check("reset_ready", int'(cfg_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Default blink: first toggle lands on edge 2049 after release.
        repeat (2048) @(posedge clk);
        #1;
        check("dflt_edge2048", int'(led_o), 5);
        @(posedge clk);
        #1;
        check("dflt_edge2049", int'(led_o), 2);
        repeat (2047) @(posedge clk);
        #1;
        check("dflt_edge4096", int'(led_o), 2);
        @(posedge clk);
        #1;
        check("dflt_edge4097", int'(led_o), 5);

        // ch0 BLINK, half = 3: four cycles dark-driven (1), four lit (0).
        send(0, 2, 3);
        check("blink_ready_low", int'(cfg_ready), 0);
        for (int j = 0; j < 16; j++) begin
            @(posedge clk);
            #1;
            check("blink_ch0", int'(led_o[0]), ((j % 8) < 4) ? 1 : 0);
        end

        // ch1 ON, then OFF two cycles later.
        send(1, 1, 0);
        check("on_ready_low", int'(cfg_ready), 0);
        @(posedge clk);
        #1;
        check("on_led1", int'(led_o[1]), 0);
        check("on_ready_high", int'(cfg_ready), 1);
        send(1, 0, 0);
        check("off_ready_low", int'(cfg_ready), 0);
        @(posedge clk);
        #1;
        check("off_led1", int'(led_o[1]), 1);

        // ch0 BREATHE with a step every cycle; scoreboard checks PWM vs level.
        send(0, 3, 0);
        repeat (40) @(posedge clk);
        #1;
        send(2, 3, 2);
        repeat (60) @(posedge clk);
        #1;

        // Held request to a non-existent channel: two accepts, no state change.
        cfg_valid = 1'b1;
        cfg_ch    = 2'd3;
        cfg_mode  = 2'd1;
        cfg_half  = 11'd5;
        for (int j = 0; j < 4; j++) begin
            check("badch_ready", int'(cfg_ready), (j % 2 == 0) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Randomised traffic, including payload churn while cfg_ready is low.
        for (int j = 0; j < 400; j++) begin
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch    = CH_W'($urandom_range(0, 3));
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_half  = CNT_W'($urandom_range(0, 5));
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset pulse mid-BREATHE, entirely between clock edges.
        send(0, 3, 1);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("pulse_led", int'(led_o), 5);
        check("pulse_ready", int'(cfg_ready), 1);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send(1, 2, 0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
